sblk_inst_sched: RTL
====================

Name: sblk_inst_sched

Overview:
- Instruction scheduler in front of the sblk controller.
- Buffers packed loop instructions from the host and issues them one at a time as a one-cycle inst_en pulse.
- Tracks the controller's status_sblk busy/done handshake, counts completed instructions, and flags malformed instructions and start timeouts.
- Sits between the host/config interface and sblk_ctrl.

Parameters:
- WID_INST_TN, 4, width of n_tn field.
- WID_INST_TM, 9, width of n_tm field.
- WID_INST_TP, 5, width of n_tp field.
- WID_INST_LN, 5, width of n_ln field.
- WID_INST_LP, 5, width of n_lp field.
- WID_INST, sum of the five field widths (28), packed instruction width, order {n_lp,n_ln,n_tp,n_tm,n_tn}.
- FIFO_DEPTH, 4, instruction queue depth; power of 2, at least 2.
- START_TIMEOUT, 64, cycles allowed from issue until status_sblk rises.
- WID_CNT, 16, completed-instruction counter width.

Ports:
- clk_l  in  1  clock.
- rst  in  1  synchronous active-high reset.
- host_inst  in  WID_INST  packed instruction from host.
- host_vld  in  1  host instruction valid.
- host_rdy  out  1  queue can accept; transfer when host_vld & host_rdy.
- flush  in  1  drop all queued, not-yet-issued instructions.
- inst_data  out  WID_INST  instruction to sblk_ctrl, held stable from issue until the next issue.
- inst_en  out  1  one-cycle issue pulse to sblk_ctrl.
- status_sblk  in  1  sblk_ctrl busy flag.
- q_level  out  $clog2(FIFO_DEPTH)+1  queued instruction count.
- done_pulse  out  1  one cycle per completed instruction.
- done_cnt  out  WID_CNT  completed instructions, wraps at 2^WID_CNT.
- err_zero  out  1  sticky: an instruction with a zero field was dropped.
- err_timeout  out  1  sticky: status_sblk did not rise within START_TIMEOUT.
- idle  out  1  FSM in IDLE and queue empty.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - FIFO emptied; FSM goes to IDLE.
  - inst_en=0, inst_data=0, done_pulse=0, done_cnt=0, err_zero=0, err_timeout=0, q_level=0.
  - host_rdy=0 while rst is high, 1 otherwise when the queue is not full; idle=1 after reset.
  - Reset mid-operation aborts tracking; a command already issued to sblk_ctrl is not cancelled.
- Enqueue:
  - On host_vld & host_rdy, if any of the five fields is zero: the instruction is not queued, err_zero is set, and the host handshake still completes.
  - Otherwise the instruction is written at the tail.
  - host_rdy = (q_level < FIFO_DEPTH) & ~rst; it is combinational from q_level.
  - A pop and a push in the same cycle leave q_level unchanged. A push while full is impossible because host_rdy=0.
- Flush:
  - Empties the queue in that cycle and overrides any same-cycle push, which is discarded.
  - The FSM is unaffected; an in-flight instruction completes normally.
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE:
  - Go to ISSUE when q_level>0 and status_sblk=0.
  - At that edge, inst_data <= FIFO head, the head is popped, and inst_en is registered high.
- ISSUE (1 cycle):
  - inst_en=1; clear the timeout counter; go to WAIT_BUSY.
  - Latency: 1 cycle from the queue becoming non-empty to inst_en=1.
- WAIT_BUSY:
  - If status_sblk=1, go to RUN.
  - Otherwise increment the timeout counter. When it reaches START_TIMEOUT, set err_timeout and go to IDLE with no done_pulse and no count.
- RUN: go to DONE on status_sblk=0.
- DONE (1 cycle): done_pulse=1, done_cnt+1 (wraps), go to IDLE.
  - Minimum issue-to-issue spacing is therefore ISSUE, WAIT_BUSY, RUN, DONE, IDLE.
- Error flags: err_zero and err_timeout clear only on rst.
- Outputs: all are registered except host_rdy and idle.

Test Plan:
- Single instruction. After reset, push {lp=2,ln=3,tp=1,tm=1,tn=4}; a model raises status_sblk 2 cycles after inst_en and holds it 20 cycles.
  - Required: inst_en high for exactly 1 cycle, 1 cycle after the push.
  - Required: inst_data=the packed value; done_pulse 1 cycle after status_sblk falls; done_cnt=1; idle=1.
- Back-to-back queueing. Push 5 valid instructions on consecutive cycles with the sblk model busy.
  - Required: host_rdy drops after 4 accepted with q_level=4; the 5th is held.
  - Required: the 5th is accepted after the first issue; issues occur in FIFO order; each inst_en waits for the previous done_pulse; final done_cnt=5.
- Zero field. Push one instruction with n_tm=0, then one valid instruction.
  - Required: err_zero=1; q_level shows only the valid one; exactly one inst_en; done_cnt=1.
- Timeout. The model never raises status_sblk.
  - Required: err_timeout=1 exactly START_TIMEOUT cycles after WAIT_BUSY entry; FSM returns to IDLE; the next queued instruction issues; done_cnt unchanged.
- Flush and simultaneous push. Queue 3 instructions while one is running, then assert flush together with host_vld.
  - Required: q_level=0 next cycle; the running instruction still gives done_pulse; no further inst_en.
- Reset mid-RUN. Assert rst for 1 cycle while in RUN with 2 queued.
  - Required: all outputs return to reset values; q_level=0; no done_pulse for the aborted instruction.

Source files
------------

// File: rtl/sblk_inst_sched.sv
// sblk_inst_sched: instruction scheduler sitting between the host/config
// interface and sblk_ctrl. Packed loop instructions from the host are
// buffered in a small FIFO. They are handed to the controller one at a time
// as a single-cycle inst_en pulse. The scheduler then follows the
// controller's busy flag through to completion.
//
// Ports:
//   clk_l        clock
//   rst          synchronous active-high reset
//   host_inst    packed instruction {n_lp,n_ln,n_tp,n_tm,n_tn}
//   host_vld     host instruction valid
//   host_rdy     queue can accept (transfer on host_vld & host_rdy)
//   flush        drop every queued, not-yet-issued instruction
//   inst_data    instruction to sblk_ctrl, held from one issue to the next
//   inst_en      one-cycle issue pulse to sblk_ctrl
//   status_sblk  sblk_ctrl busy flag
//   q_level      number of queued instructions
//   done_pulse   one cycle per completed instruction
//   done_cnt     completed instruction count (wraps)
//   err_zero     sticky: an instruction with a zero field was dropped
//   err_timeout  sticky: status_sblk did not rise in time after an issue
//   idle         FSM idle and queue empty
module sblk_inst_sched #(
  parameter int WID_INST_TN   = 4,
  parameter int WID_INST_TM   = 9,
  parameter int WID_INST_TP   = 5,
  parameter int WID_INST_LN   = 5,
  parameter int WID_INST_LP   = 5,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 64,
  parameter int WID_CNT       = 16,
  localparam int WID_INST = WID_INST_TN + WID_INST_TM + WID_INST_TP +
                            WID_INST_LN + WID_INST_LP,
  localparam int WID_LVL  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_l,
  input  logic                rst,
  input  logic [WID_INST-1:0] host_inst,
  input  logic                host_vld,
  output logic                host_rdy,
  input  logic                flush,
  output logic [WID_INST-1:0] inst_data,
  output logic                inst_en,
  input  logic                status_sblk,
  output logic [WID_LVL-1:0]  q_level,
  output logic                done_pulse,
  output logic [WID_CNT-1:0]  done_cnt,
  output logic                err_zero,
  output logic                err_timeout,
  output logic                idle
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TMO_W  = $clog2(START_TIMEOUT + 1);
  localparam int OFF_TM = WID_INST_TN;
  localparam int OFF_TP = OFF_TM + WID_INST_TM;
  localparam int OFF_LN = OFF_TP + WID_INST_TP;
  localparam int OFF_LP = OFF_LN + WID_INST_LN;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WID_INST-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [TMO_W-1:0]    tmo_cnt;

  logic host_xfer, has_zero, push, pop, go_issue, tmo_hit, run_end;

  // A field of zero would make sblk_ctrl run a degenerate loop, so such
  // instructions are consumed from the host but never queued.
  assign has_zero = (host_inst[OFF_TM-1:0] == '0) |
                    (host_inst[OFF_TP-1:OFF_TM] == '0) |
                    (host_inst[OFF_LN-1:OFF_TP] == '0) |
                    (host_inst[OFF_LP-1:OFF_LN] == '0) |
                    (host_inst[WID_INST-1:OFF_LP] == '0);

  assign host_rdy  = (q_level < WID_LVL'(FIFO_DEPTH)) & ~rst;
  assign host_xfer = host_vld & host_rdy;
  // Flush wins over a same-cycle push: the pushed word is discarded.
  assign push      = host_xfer & ~has_zero & ~flush;
  // Issue only once the controller has dropped busy from any prior command,
  // including one still running across a reset.
  assign go_issue  = (state == IDLE) & (q_level != '0) & ~status_sblk;
  assign pop       = go_issue;
  assign tmo_hit   = (state == WAIT_BUSY) & ~status_sblk &
                     (tmo_cnt == TMO_W'(START_TIMEOUT - 1));
  assign run_end   = (state == RUN) & ~status_sblk;
  assign idle      = (state == IDLE) & (q_level == '0);

  // Queue storage; push already excludes reset through host_rdy.
  always_ff @(posedge clk_l) begin
    if (push) mem[wr_ptr] <= host_inst;
  end

  // Queue pointers and level. Pointers wrap freely since the depth is a
  // power of two; flush collapses the read side onto the write side.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      q_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   q_level <= q_level + WID_LVL'(1);
        2'b01:   q_level <= q_level - WID_LVL'(1);
        default: q_level <= q_level;
      endcase
      if (flush) begin
        rd_ptr  <= wr_ptr;
        q_level <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_l) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic for the issue / busy / done handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go_issue) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (status_sblk)  state_nxt = RUN;
        else if (tmo_hit) state_nxt = IDLE;
      end
      RUN:       if (!status_sblk) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Registered outputs, completion counter, sticky errors and the start
  // timeout counter. The counter restarts in ISSUE and runs only while
  // waiting for busy.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      inst_data   <= '0;
      inst_en     <= 1'b0;
      done_pulse  <= 1'b0;
      done_cnt    <= '0;
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      inst_en    <= go_issue;
      done_pulse <= run_end;
      if (pop)     inst_data <= mem[rd_ptr];
      if (run_end) done_cnt  <= done_cnt + WID_CNT'(1);
      if (host_xfer & has_zero) err_zero <= 1'b1;
      if (tmo_hit) err_timeout <= 1'b1;
      if (state == ISSUE) tmo_cnt <= '0;
      else if ((state == WAIT_BUSY) & ~status_sblk) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

endmodule
